// File: rtl/ddr_cmd_scheduler_pkg.sv
// Shared types for the DDR command scheduler: burst sizes, PHY command
// encodings, FSM states, arbiter result classes and the burst-length helper.
package ddr_cmd_scheduler_pkg;

  typedef enum logic [1:0] {
    ONE_BYTE,
    TWO_BYTES,
    FOUR_BYTES,
    EIGHT_BYTES
  } burst_size_t;

  typedef enum logic [1:0] {
    CMD_PRE,
    CMD_ACT,
    CMD_RD,
    CMD_WR
  } ddr_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    PRE_WAIT,
    ACT,
    ACT_WAIT,
    ISSUE,
    DATA_WAIT
  } sched_state_t;

  // Where the selected access lands relative to the tracked row.
  typedef enum logic [1:0] {
    SEL_HIT,
    SEL_MISS,
    SEL_CLOSED
  } sel_class_t;

  // Wide enough for the longest data phase (T_CL + 8 beats - 1).
  localparam int TIMER_W = 5;

  // Number of data beats a burst occupies on the bus.
  function automatic logic [TIMER_W-1:0] burst_beats(input burst_size_t b);
    case (b)
      ONE_BYTE:    return 5'd1;
      TWO_BYTES:   return 5'd2;
      FOUR_BYTES:  return 5'd4;
      EIGHT_BYTES: return 5'd8;
      default:     return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ddr_cmd_scheduler_if.sv
// Bundles the read/write pool heads, pool pop strobes and the PHY command port.
// The scheduler uses the master view; pools/PHY (or a bench) use the slave view.
interface ddr_cmd_scheduler_if #(
  parameter int ADDR_SIZE = 8
);
  import ddr_cmd_scheduler_pkg::*;

  logic                 rready;
  logic [ADDR_SIZE-1:0] pool_raddr;
  burst_size_t          pool_rburst_size;
  logic                 raw;
  logic                 wready;
  logic [ADDR_SIZE-1:0] pool_waddr;
  burst_size_t          pool_wburst_size;
  logic                 cmd_ready;
  logic                 cmd_valid;
  ddr_cmd_t             cmd_type;
  logic [ADDR_SIZE-1:0] cmd_addr;
  burst_size_t          cmd_burst;
  logic                 read_issued;
  logic                 write_issued;
  logic                 rbusy;
  logic                 wbusy;

  modport master (
    input  rready, pool_raddr, pool_rburst_size, raw,
    input  wready, pool_waddr, pool_wburst_size, cmd_ready,
    output cmd_valid, cmd_type, cmd_addr, cmd_burst,
    output read_issued, write_issued, rbusy, wbusy
  );

  modport slave (
    output rready, pool_raddr, pool_rburst_size, raw,
    output wready, pool_waddr, pool_wburst_size, cmd_ready,
    input  cmd_valid, cmd_type, cmd_addr, cmd_burst,
    input  read_issued, write_issued, rbusy, wbusy
  );

endinterface

// File: rtl/ddr_cmd_scheduler_sched_arbiter.sv
// Combinational IDLE-state selection between the read and write pool heads:
// starvation override first, then row-hit preference, then read wins ties.
module ddr_cmd_scheduler_sched_arbiter
  import ddr_cmd_scheduler_pkg::*;
#(
  parameter int ROW_W        = 5,
  parameter int CNT_W        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             rready,
  input  logic             raw,
  input  logic             wready,
  input  logic [ROW_W-1:0] rrow,
  input  logic [ROW_W-1:0] wrow,
  input  logic [ROW_W-1:0] open_row,
  input  logic             row_open,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             sel_valid,
  output logic             sel_write,
  output sel_class_t       sel_class
);

  logic rcand;
  logic wcand;
  logic rhit;
  logic whit;
  logic starved;
  logic chosen_hit;

  // A head being forwarded (raw) is leaving the pool and must not be picked.
  assign rcand   = rready && !raw;
  assign wcand   = wready;
  assign rhit    = row_open && (rrow == open_row);
  assign whit    = row_open && (wrow == open_row);
  assign starved = wcand && (starve_cnt >= CNT_W'(STARVE_LIMIT));

  // Pick the direction: forced write, else hit beats miss, else read.
  always_comb begin
    sel_write = 1'b0;
    if (starved) begin
      sel_write = 1'b1;
    end else if (rcand && wcand) begin
      sel_write = whit && !rhit;
    end else begin
      sel_write = wcand;
    end
  end

  assign sel_valid  = rcand || wcand;
  assign chosen_hit = sel_write ? whit : rhit;
  assign sel_class  = chosen_hit ? SEL_HIT : (row_open ? SEL_MISS : SEL_CLOSED);

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// DDR command scheduler: selects a pool head, walks PRE/ACT/RD-WR with timing
// gaps, keeps one row open between accesses and pops the pool after issue.
module ddr_cmd_scheduler
  import ddr_cmd_scheduler_pkg::*;
#(
  parameter int ADDR_SIZE    = 8,
  parameter int T_RP         = 3,
  parameter int T_RCD        = 3,
  parameter int T_CL         = 4,
  parameter int T_WL         = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 n_rst,
  ddr_cmd_scheduler_if.master bus
);

  localparam int ROW_W = ADDR_SIZE - 3;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  sched_state_t         state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 sel_write_q, sel_write_d;
  logic [ADDR_SIZE-1:0] sel_addr_q, sel_addr_d;
  burst_size_t          sel_burst_q, sel_burst_d;
  logic                 row_open_q, row_open_d;
  logic [ROW_W-1:0]     open_row_q, open_row_d;
  logic [CNT_W-1:0]     starve_q, starve_d;
  logic                 read_issued_q, read_issued_d;
  logic                 write_issued_q, write_issued_d;

  logic       arb_valid;
  logic       arb_write;
  sel_class_t arb_class;

  ddr_cmd_scheduler_sched_arbiter #(
    .ROW_W        (ROW_W),
    .CNT_W        (CNT_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_sched_arbiter (
    .rready     (bus.rready),
    .raw        (bus.raw),
    .wready     (bus.wready),
    .rrow       (bus.pool_raddr[ADDR_SIZE-1:3]),
    .wrow       (bus.pool_waddr[ADDR_SIZE-1:3]),
    .open_row   (open_row_q),
    .row_open   (row_open_q),
    .starve_cnt (starve_q),
    .sel_valid  (arb_valid),
    .sel_write  (arb_write),
    .sel_class  (arb_class)
  );

  // Next-state, selection latch, row tracking, timers and pop strobes.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    sel_write_d    = sel_write_q;
    sel_addr_d     = sel_addr_q;
    sel_burst_d    = sel_burst_q;
    row_open_d     = row_open_q;
    open_row_d     = open_row_q;
    starve_d       = starve_q;
    read_issued_d  = 1'b0;
    write_issued_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          sel_write_d = arb_write;
          sel_addr_d  = arb_write ? bus.pool_waddr : bus.pool_raddr;
          sel_burst_d = arb_write ? bus.pool_wburst_size : bus.pool_rburst_size;
          if (arb_write) begin
            starve_d = '0;
          end else if (bus.wready && (starve_q < CNT_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + CNT_W'(1);
          end
          case (arb_class)
            SEL_HIT:  state_d = ISSUE;
            SEL_MISS: state_d = PRE;
            default:  state_d = ACT;
          endcase
        end
      end
      PRE: begin
        if (bus.cmd_ready) begin
          row_open_d = 1'b0;
          timer_d    = TIMER_W'(T_RP - 1);
          state_d    = PRE_WAIT;
        end
      end
      PRE_WAIT: begin
        if (timer_q == '0) state_d = ACT;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      ACT: begin
        if (bus.cmd_ready) begin
          open_row_d = sel_addr_q[ADDR_SIZE-1:3];
          row_open_d = 1'b1;
          timer_d    = TIMER_W'(T_RCD - 1);
          state_d    = ACT_WAIT;
        end
      end
      ACT_WAIT: begin
        if (timer_q == '0) state_d = ISSUE;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      ISSUE: begin
        if (bus.cmd_ready) begin
          timer_d = (sel_write_q ? TIMER_W'(T_WL) : TIMER_W'(T_CL))
                    + burst_beats(sel_burst_q) - TIMER_W'(1);
          // The pop lands one cycle after the accept so the pool never sees
          // a combinational path from its own ready/raw back to the pop.
          read_issued_d  = !sel_write_q;
          write_issued_d = sel_write_q;
          state_d        = DATA_WAIT;
        end
      end
      DATA_WAIT: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any sequence without a pop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      sel_write_q    <= 1'b0;
      sel_addr_q     <= '0;
      sel_burst_q    <= ONE_BYTE;
      row_open_q     <= 1'b0;
      open_row_q     <= '0;
      starve_q       <= '0;
      read_issued_q  <= 1'b0;
      write_issued_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      sel_write_q    <= sel_write_d;
      sel_addr_q     <= sel_addr_d;
      sel_burst_q    <= sel_burst_d;
      row_open_q     <= row_open_d;
      open_row_q     <= open_row_d;
      starve_q       <= starve_d;
      read_issued_q  <= read_issued_d;
      write_issued_q <= write_issued_d;
    end
  end

  // Command type decoded from state and the latched direction.
  always_comb begin
    bus.cmd_type = CMD_PRE;
    case (state_q)
      ACT:     bus.cmd_type = CMD_ACT;
      ISSUE:   bus.cmd_type = sel_write_q ? CMD_WR : CMD_RD;
      default: bus.cmd_type = CMD_PRE;
    endcase
  end

  assign bus.cmd_valid    = (state_q == PRE) || (state_q == ACT) || (state_q == ISSUE);
  assign bus.cmd_addr     = bus.cmd_valid ? sel_addr_q : '0;
  assign bus.cmd_burst    = (state_q == ISSUE) ? sel_burst_q : ONE_BYTE;
  assign bus.read_issued  = read_issued_q;
  assign bus.write_issued = write_issued_q;
  assign bus.rbusy        = (state_q != IDLE) && !sel_write_q;
  assign bus.wbusy        = (state_q != IDLE) && sel_write_q;

endmodule
